pipe_chain: RTL

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 86 ++++++++
 1 files changed

// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage valid/allowin handshake pipeline; `PIPE_CHAIN_PERF_CNT_EN adds stall/bubble counters
module pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_bus,
    output logic                   in_allowin,
    input  logic [DEPTH-1:0]       stage_ready_go,
    input  logic [DEPTH-1:0]       flush_mask,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_bus,
    input  logic                   out_allowin,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_bus
`ifdef PIPE_CHAIN_PERF_CNT_EN
    ,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            bubble_cnt
`endif
);
    logic [DEPTH-1:0] valid_q, valid_d, allowin, src_valid;
    logic [WIDTH-1:0] bus_q [DEPTH];
    logic [WIDTH-1:0] bus_d [DEPTH];
    logic [WIDTH-1:0] src_bus [DEPTH];
    logic             chain;
    // allowin ripples back from the downstream consumer through every stage
    always_comb begin
        chain = out_allowin;
        allowin = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain = !valid_q[i] || (stage_ready_go[i] && chain);
            allowin[i] = chain;
        end
    end
    // upstream source of each stage: the input port for stage 0, the previous stage otherwise
    always_comb begin
        src_valid = '0;
        src_valid[0] = in_valid;
        src_bus[0] = in_bus;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = valid_q[i-1] && stage_ready_go[i-1];
            src_bus[i] = bus_q[i-1];
        end
    end
    // flush kills the valid bit only; the payload still loads so a flushed handoff counts as consumed
    always_comb begin
        valid_d = valid_q;
        bus_d = bus_q;
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = flush_mask[i] ? 1'b0 : allowin[i] ? src_valid[i] : valid_q[i];
            bus_d[i] = (src_valid[i] && allowin[i]) ? src_bus[i] : bus_q[i];
        end
    end
    // stage registers; payloads need no reset
    always_ff @(posedge clk) begin
        valid_q <= reset ? '0 : valid_d;
        bus_q <= bus_d;
    end
    // pack per-stage payloads for the hazard taps
    always_comb begin
        stage_bus = '0;
        for (int i = 0; i < DEPTH; i++) stage_bus[i*WIDTH +: WIDTH] = bus_q[i];
    end
    assign in_allowin  = allowin[0];
    assign out_valid   = valid_q[DEPTH-1] && stage_ready_go[DEPTH-1];
    assign out_bus     = bus_q[DEPTH-1];
    assign stage_valid = valid_q;
`ifdef PIPE_CHAIN_PERF_CNT_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q;
    // saturating performance counters, independent of flush
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (in_valid && !in_allowin && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (!out_valid && bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif
endmodule
